// File: rtl/seg7_ctrl.sv
// seg7_ctrl: memory-mapped 4-digit multiplexed 7-segment display driver.
// Registers: DATA (0x0), CTRL (0x4), BLINK (0x8), STATUS (0xC, read-only).
// The prescaler produces one tick every SCAN_DIV clocks; each tick advances
// the digit slot sequencer DIG0->DIG1->DIG2->DIG3->DIG0. Segment and digit
// select pins are active low and registered.
// Optional feature macro: SEG7_CTRL_BLINK_EN (per-digit blinking; when not
// defined the blink counter, phase and BLINK register do not exist).
module seg7_ctrl #(
    parameter int SCAN_DIV  = 25000,
    parameter int BLINK_DIV = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [3:0]  rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_n
);

    localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

`ifdef SEG7_CTRL_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
`endif

    // Slot sequencer states; the encoding doubles as the scan index.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } slot_t;

    slot_t              state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [19:0]        data_q,  data_d;
    logic               en_q,    en_d;
    logic [3:0]         digen_q, digen_d;
    logic [7:0]         seg_n_q, seg_n_d;
    logic [3:0]         dig_n_q, dig_n_d;
`ifdef SEG7_CTRL_BLINK_EN
    logic [3:0]         blink_q, blink_d;
    logic [BLINK_W-1:0] bcnt_q,  bcnt_d;
    logic               phase_q, phase_d;
`endif

    logic        tick_s;
    logic        wr_ok_s;
    logic [1:0]  idx_s;
    logic [3:0]  nib_s;
    logic [3:0]  dp_s;
    logic        blanked_s;
    logic        lit_s;
    logic        unused_s;

    // Active-low a..g pattern for one hex digit, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7_n(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign idx_s    = state_q;
    assign wr_ok_s  = wr_en && (wr_strb == 4'b1111);
    assign nib_s    = data_q[{idx_s, 2'b00} +: 4];
    assign dp_s     = data_q[19:16];
    // Byte-lane and high data bits that no register decodes.
    assign unused_s = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:20]};

    // Next-state logic: prescaler, slot sequencer, blink, register writes, pins.
    always_comb begin
        tick_s    = 1'b0;
        presc_d   = presc_q - PRESC_W'(1);
        state_d   = state_q;
        data_d    = data_q;
        en_d      = en_q;
        digen_d   = digen_q;
        seg_n_d   = 8'hFF;
        dig_n_d   = 4'hF;
        blanked_s = 1'b0;
        lit_s     = 1'b0;
`ifdef SEG7_CTRL_BLINK_EN
        blink_d   = blink_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
`endif

        // Prescaler reloads on the tick.
        if (presc_q == {PRESC_W{1'b0}}) begin
            tick_s  = 1'b1;
            presc_d = PRESC_MAX;
        end else begin
            presc_d = presc_q - PRESC_W'(1);
        end

        // Slot sequencer advances once per tick, independent of EN.
        case (state_q)
            DIG0:    state_d = tick_s ? DIG1 : DIG0;
            DIG1:    state_d = tick_s ? DIG2 : DIG1;
            DIG2:    state_d = tick_s ? DIG3 : DIG2;
            DIG3:    state_d = tick_s ? DIG0 : DIG3;
            default: state_d = DIG0;
        endcase

`ifdef SEG7_CTRL_BLINK_EN
        // Blink counter spans BLINK_DIV ticks per half-period.
        if (tick_s) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = {BLINK_W{1'b0}};
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BLINK_W'(1);
            end
        end else begin
            bcnt_d = bcnt_q;
        end
        blanked_s = phase_q & blink_q[idx_s];
`else
        blanked_s = 1'b0;
`endif

        // Register writes only take effect with all byte strobes set.
        if (wr_ok_s) begin
            case (wr_addr[3:2])
                2'd0: data_d = wr_data[19:0];
                2'd1: begin
                    en_d    = wr_data[0];
                    digen_d = wr_data[7:4];
                end
                2'd2: begin
`ifdef SEG7_CTRL_BLINK_EN
                    blink_d = wr_data[3:0];
`endif
                end
                default: begin
                    // STATUS is read-only.
                end
            endcase
        end else begin
            data_d = data_q;
        end

        // Pin values for the slot currently being scanned; a dark slot
        // still occupies its full time so brightness stays uniform.
        lit_s = en_q & digen_q[idx_s] & ~blanked_s;
        if (lit_s) begin
            dig_n_d = ~(4'b0001 << idx_s);
            seg_n_d = {~dp_s[idx_s], hex7_n(nib_s)};
        end else begin
            dig_n_d = 4'hF;
            seg_n_d = 8'hFF;
        end
    end

    // State, register file and pin registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIG0;
            presc_q <= PRESC_MAX;
            data_q  <= 20'h0_0000;
            en_q    <= 1'b0;
            digen_q <= 4'h0;
            seg_n_q <= 8'hFF;
            dig_n_q <= 4'hF;
`ifdef SEG7_CTRL_BLINK_EN
            blink_q <= 4'h0;
            bcnt_q  <= {BLINK_W{1'b0}};
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            data_q  <= data_d;
            en_q    <= en_d;
            digen_q <= digen_d;
            seg_n_q <= seg_n_d;
            dig_n_q <= dig_n_d;
`ifdef SEG7_CTRL_BLINK_EN
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    // Combinational read mux; zero when not reading.
    always_comb begin
        rd_data = 32'h0000_0000;
        if (rd_en) begin
            case (rd_addr[3:2])
                2'd0:    rd_data = {12'h000, data_q};
                2'd1:    rd_data = {24'h00_0000, digen_q, 3'b000, en_q};
`ifdef SEG7_CTRL_BLINK_EN
                2'd2:    rd_data = {28'h000_0000, blink_q};
`else
                2'd2:    rd_data = 32'h0000_0000;
`endif
                2'd3:    rd_data = {30'h0000_0000, idx_s};
                default: rd_data = 32'h0000_0000;
            endcase
        end else begin
            rd_data = 32'h0000_0000;
        end
    end

    assign seg_n = seg_n_q;
    assign dig_n = dig_n_q;

endmodule

// File: tb/tb_seg7_ctrl.sv
// Directed self-checking bench for seg7_ctrl with SCAN_DIV=4, BLINK_DIV=8.
// Pins are checked at the falling edge; the pins seen after rising edge e
// reflect the scan position and registers as they stood after edge e-1.
module tb_seg7_ctrl;

    localparam int SCAN  = 4;
    localparam int BDIV  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wr_addr = 4'h0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_strb = 4'h0;
    logic [3:0]  rd_addr = 4'h0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    // Bench-side copies of what software wrote.
    logic [19:0] m_data  = 20'h0;
    logic [7:0]  m_ctrl  = 8'h0;
    logic [3:0]  m_blink = 4'h0;

    seg7_ctrl #(.SCAN_DIV(SCAN), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .seg_n(seg_n), .dig_n(dig_n)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset edge.
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic [7:0] hex_exp(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Expected {dig_n, seg_n} seen after rising edge e (e >= 1).
    function automatic logic [11:0] exp_pins(input int e);
        int t, k;
        logic ph;
        logic [7:0] sg;
        logic [3:0] dg;
        t = (e - 1) / SCAN;
        k = t % 4;
`ifdef SEG7_CTRL_BLINK_EN
        ph = ((t / BDIV) % 2) == 1;
`else
        ph = 1'b0;
`endif
        if (m_ctrl[0] && m_ctrl[4 + k] && !(ph && m_blink[k])) begin
            dg = ~(4'b0001 << k);
            sg = hex_exp(m_data[4 * k +: 4]);
            sg[7] = ~m_data[16 + k];
        end else begin
            dg = 4'hF;
            sg = 8'hFF;
        end
        return {dg, sg};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_data = 20'h0; m_ctrl = 8'h0; m_blink = 4'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; wr_strb = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        rd_addr = a; rd_en = 1'b1;
        #1;
        v = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] ex;
        do_reset();
        n_cmp++;
        if ({dig_n, seg_n} !== 12'hFFF) begin
            n_bad++;
            $display("FAIL reset_pins: got dig=%h seg=%h want dig=F seg=FF", dig_n, seg_n);
        end
        for (int a = 0; a < 4; a++) begin
            rd(4'(a * 4), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %h want 00000000", a, v);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rd(4'hC, v);
            ex = (i >= 4) ? 32'h1 : 32'h0;
            n_cmp++;
            if (v !== ex) begin
                n_bad++;
                $display("FAIL reset_status_cyc%0d: got %h want %h", i, v, ex);
            end
        end
    endtask

    task automatic check_window(input string nm, input int cycles);
        logic [11:0] ex;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            ex = exp_pins(edges);
            n_cmp++;
            if ({dig_n, seg_n} !== ex) begin
                n_bad++;
                $display("FAIL %s edge %0d: got dig=%h seg=%h want dig=%h seg=%h",
                         nm, edges, dig_n, seg_n, ex[11:8], ex[7:0]);
            end
        end
    endtask

    task automatic test_scan();
        logic [31:0] v;
        do_reset();
        wr(4'h0, 32'h0008_1F80, 4'hF); m_data = 20'h8_1F80;
        wr(4'h4, 32'h0000_00F1, 4'hF); m_ctrl = 8'hF1;
        rd(4'h0, v);
        n_cmp++;
        if (v !== 32'h0008_1F80) begin
            n_bad++; $display("FAIL scan_data_rb: got %h want 00081F80", v);
        end
        rd(4'h4, v);
        n_cmp++;
        if (v !== 32'h0000_00F1) begin
            n_bad++; $display("FAIL scan_ctrl_rb: got %h want 000000F1", v);
        end
        check_window("scan", 40);
    endtask

    task automatic test_enable();
        wr(4'h4, 32'h0000_0051, 4'hF); m_ctrl = 8'h51;
        check_window("enable_51", 32);
        wr(4'h4, 32'h0000_00F0, 4'hF); m_ctrl = 8'hF0;
        check_window("enable_f0", 16);
    endtask

    task automatic test_blink();
        logic [31:0] v;
        do_reset();
        wr(4'h0, 32'h0008_1F80, 4'hF); m_data = 20'h8_1F80;
        wr(4'h4, 32'h0000_00F1, 4'hF); m_ctrl = 8'hF1;
        wr(4'h8, 32'h0000_0001, 4'hF);
`ifdef SEG7_CTRL_BLINK_EN
        m_blink = 4'h1;
`endif
        rd(4'h8, v);
        n_cmp++;
        if (v !== {28'h0, m_blink}) begin
            n_bad++; $display("FAIL blink_rb: got %h want %h", v, {28'h0, m_blink});
        end
        check_window("blink", 150);
    endtask

    task automatic test_strobe_latency();
        logic [31:0] v;
        logic [31:0] ex;
        do_reset();
        wr(4'h0, 32'h0008_1F80, 4'hF); m_data = 20'h8_1F80;
        wr(4'h4, 32'h0000_00F1, 4'hF); m_ctrl = 8'hF1;
        wr(4'h0, 32'hFFFF_FFFF, 4'b0011);
        rd(4'h0, v);
        n_cmp++;
        if (v !== 32'h0008_1F80) begin
            n_bad++; $display("FAIL strobe_partial: got %h want 00081F80", v);
        end
        for (int i = 0; i < 32 && (edges % 16) != 1; i++) @(negedge clk);
        n_cmp++;
        if ((edges % 16) != 1) begin
            n_bad++; $display("FAIL latency_align: got edge %0d want edge mod 16 = 1", edges);
        end
        wr(4'h0, 32'h0000_0005, 4'hF);
        n_cmp++;
        if ({dig_n, seg_n} !== 12'hEC0) begin
            n_bad++; $display("FAIL latency_old: got dig=%h seg=%h want dig=E seg=C0", dig_n, seg_n);
        end
        @(negedge clk);
        n_cmp++;
        if ({dig_n, seg_n} !== 12'hE92) begin
            n_bad++; $display("FAIL latency_new: got dig=%h seg=%h want dig=E seg=92", dig_n, seg_n);
        end
        wr(4'h0, 32'hFFFF_FFFF, 4'hF);
        wr(4'h4, 32'hFFFF_FFFF, 4'hF);
        wr(4'h8, 32'hFFFF_FFFF, 4'hF);
        wr(4'hC, 32'hFFFF_FFFF, 4'hF);
        rd(4'h0, v);
        n_cmp++;
        if (v !== 32'h000F_FFFF) begin
            n_bad++; $display("FAIL mask_data: got %h want 000FFFFF", v);
        end
        rd(4'h4, v);
        n_cmp++;
        if (v !== 32'h0000_00F1) begin
            n_bad++; $display("FAIL mask_ctrl: got %h want 000000F1", v);
        end
        rd(4'h8, v);
`ifdef SEG7_CTRL_BLINK_EN
        ex = 32'h0000_000F;
`else
        ex = 32'h0000_0000;
`endif
        n_cmp++;
        if (v !== ex) begin
            n_bad++; $display("FAIL mask_blink: got %h want %h", v, ex);
        end
        rd(4'hC, v);
        ex = 32'((edges / SCAN) % 4);
        n_cmp++;
        if (v !== ex) begin
            n_bad++; $display("FAIL status_track: got %h want %h", v, ex);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        do_reset();
        wr(4'h0, 32'h0008_1F80, 4'hF); m_data = 20'h8_1F80;
        wr(4'h4, 32'h0000_00F1, 4'hF); m_ctrl = 8'hF1;
        wr(4'h8, 32'h0000_000F, 4'hF);
`ifdef SEG7_CTRL_BLINK_EN
        m_blink = 4'hF;
`endif
        for (int i = 0; i < 100 && edges != 41; i++) @(negedge clk);
        n_cmp++;
        if ({dig_n, seg_n} !== exp_pins(edges)) begin
            n_bad++;
            $display("FAIL midrst_pre: got dig=%h seg=%h want %h", dig_n, seg_n, exp_pins(edges));
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dig_n, seg_n} !== 12'hFFF) begin
            n_bad++; $display("FAIL midrst_pins: got dig=%h seg=%h want dig=F seg=FF", dig_n, seg_n);
        end
        for (int a = 0; a < 4; a++) begin
            rd(4'(a * 4), v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_bad++; $display("FAIL midrst_reg%0d: got %h want 00000000", a, v);
            end
        end
        rst = 1'b0;
        m_data = 20'h0; m_ctrl = 8'h0; m_blink = 4'h0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_enable();
        test_blink();
        test_strobe_latency();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
